// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a length-prefixed program image into byte-wide instruction memory.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int DEPTH     = 400,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0]       MAX_LEN = 17'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       length_q, length_d;
  logic [15:0]       count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              beat;
  logic [15:0]       len_new;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        chk_total;
`endif

  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_q == S_CHK)
`endif
               ;
    beat        = in_valid && in_ready;
    len_new     = {length_q[15:8], in_data};
    state_d     = state_q;
    length_d    = length_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    chk_total   = sum_q + in_data;
`endif
    case (state_q)
      S_LEN_HI: if (beat) begin
        length_d[15:8] = in_data;
        state_d        = S_LEN_LO;
      end
      S_LEN_LO: if (beat) begin
        length_d[7:0] = in_data;
        // Oversized or non-word-multiple images are rejected before any write.
        if (({1'b0, len_new} > MAX_LEN) || (len_new[1:0] != 2'b00)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else if (len_new == 16'd0) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (beat) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_A + count_q[ADDR_W-1:0];
        mem_wdata_d = in_data;
        count_d     = count_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q + in_data;
`endif
        if (count_q == length_q - 16'd1) state_d = S_FINAL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (beat) begin
        if (chk_total == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
`endif
      S_DONE: begin
        // Release lands one cycle after entry, so it never overlaps the last write.
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
        if (start) begin
          state_d   = S_LEN_HI;
          done_d    = 1'b0;
          cpu_rst_d = 1'b1;
          count_d   = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = 8'd0;
`endif
        end
      end
      S_ERR: begin
        error_d   = 1'b1;
        cpu_rst_d = 1'b1;
        if (start) begin
          state_d = S_LEN_HI;
          error_d = 1'b0;
          count_d = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN_HI;
      length_q    <= 16'd0;
      count_q     <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader.
module tb_imem_boot_loader;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  imem_boot_loader #(.DEPTH(400), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          first_we = -1;
  int          last_we = -1;
  logic [31:0] exp_q[$];
  logic [7:0]  img[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every write strobe is matched against the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), {8'd0, e[31:8]});
        check_eq("wr_data", 32'(mem_wdata), {24'd0, e[7:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends length, the bytes in img (with gap idle cycles between them) and,
  // when the checksum option is built, a checksum byte (corrupted if bad_chk).
  task automatic load_image(input int gap, input bit bad_chk, input bit expect_ok);
    logic [15:0] len;
    logic [7:0]  sum;
    int          w0;
    len = 16'(img.size());
    sum = 8'd0;
    w0  = n_writes;
    first_we = -1;
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({8'd0, 16'(i), img[i]});
      sum = sum + img[i];
      send_byte(img[i]);
      if (gap > 0 && i != img.size() - 1) idle(gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'd0 - sum + 8'd1 : 8'd0 - sum);
`else
    if (bad_chk) check_eq("bad_chk_unsupported", 32'(error), 32'd1);
`endif
    if (expect_ok) begin
      check_eq("done_not_with_write", 32'(done), 32'd0);
      check_eq("cpu_rst_held_at_write", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      check_eq("done_after", 32'(done), 32'd1);
      check_eq("cpu_rst_released", 32'(cpu_rst), 32'd0);
      check_eq("no_we_at_done", 32'(mem_we), 32'd0);
      check_eq("in_ready_done", 32'(in_ready), 32'd0);
    end else begin
      check_eq("error_set", 32'(error), 32'd1);
      check_eq("cpu_rst_err", 32'(cpu_rst), 32'd1);
    end
    check_eq("write_count", 32'(n_writes - w0), 32'(img.size()));
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Eight bytes back-to-back: consecutive write cycles.
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'(i));
    load_image(0, 1'b0, 1'b1);
    check_eq("b2b_span", 32'(last_we - first_we), 32'd7);

    // From DONE, start re-arms on the next cycle.
    pulse_start();
    check_eq("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("start_done", 32'(done), 32'd0);
    check_eq("start_in_ready", 32'(in_ready), 32'd1);

    // Zero-length image.
    img.delete();
    load_image(0, 1'b0, 1'b1);

    // Oversized length 404.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h94);
    check_eq("big_error", 32'(error), 32'd1);
    check_eq("big_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check_eq("big_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("big_error_held", 32'(error), 32'd1);

    // Non-multiple-of-4 length.
    pulse_start();
    check_eq("err_start_in_ready", 32'(in_ready), 32'd1);
    check_eq("err_start_error", 32'(error), 32'd0);
    send_byte(8'h00);
    send_byte(8'h06);
    check_eq("len6_error", 32'(error), 32'd1);
    check_eq("len6_in_ready", 32'(in_ready), 32'd0);

    // Gapped stream with held data between beats.
    pulse_start();
    img.delete();
    img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC); img.push_back(8'hDD);
    load_image(2, 1'b0, 1'b1);

    // Reset in the middle of DATA, then a fresh image starting at address 0.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h08);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'd0, 16'(i), 8'(8'h40 + i)});
      send_byte(8'(8'h40 + i));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
    check_eq("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    img.delete();
    img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'h44);
    load_image(0, 1'b0, 1'b1);

    // Second image after DONE overwrites from the base address.
    pulse_start();
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom_range(0, 255)));
    load_image(1, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 01 02 03 04 with F6 passes; a wrong checksum aborts; start recovers.
    pulse_start();
    img.delete();
    img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h03); img.push_back(8'h04);
    load_image(0, 1'b0, 1'b1);
    pulse_start();
    load_image(0, 1'b1, 1'b0);
    pulse_start();
    check_eq("chk_start_in_ready", 32'(in_ready), 32'd1);
    load_image(0, 1'b0, 1'b1);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
